// File: rtl/router_nport.sv
// router_nport: routes one input byte stream into NUM_PORTS output FIFOs.
// The header byte is matched against per-port address registers (lowest
// matching index wins); unmatched packets are dropped and counted. The byte
// on the first data_status=0 cycle closes the packet and carries its parity.
module router_nport #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PTR_W      = $clog2(FIFO_DEPTH),
  parameter int SEL_W      = $clog2(NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          data_status,
  input  logic [DATA_W-1:0]             data,
  output logic                          busy,
  input  logic                          mem_en,
  input  logic                          mem_rd_wr,
  input  logic [SEL_W-1:0]              mem_add,
  input  logic [DATA_W-1:0]             mem_data,
  output logic [DATA_W-1:0]             mem_rd_data,
  input  logic [NUM_PORTS-1:0]          read,
  output logic [NUM_PORTS*DATA_W-1:0]   port,
  output logic [NUM_PORTS-1:0]          ready,
  output logic                          parity_err,
  output logic [7:0]                    drop_count
);

  typedef enum logic [1:0] {IDLE, LOAD, DROP} state_t;

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [SEL_W:0] SEL_LIM  = (SEL_W+1)'(NUM_PORTS);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t               state_q, state_n;
  logic [SEL_W-1:0]     dest_q;
  logic [DATA_W-1:0]    xor_acc;
  logic [DATA_W-1:0]    addr_reg [NUM_PORTS];
  logic [NUM_PORTS-1:0] full;
  logic                 match_hit;
  logic [SEL_W-1:0]     match_idx;
  logic                 push, load_dest, drop_inc, par_chk;
  logic [SEL_W-1:0]     push_sel;
  logic                 add_ok;

  assign add_ok = ({1'b0, mem_add} < SEL_LIM);

  // Header lookup: scan downwards so the lowest matching index ends up selected.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (data == addr_reg[i]) begin
        match_hit = 1'b1;
        match_idx = SEL_W'(i);
      end
    end
  end

  // Next-state, push and backpressure decode; a busy cycle accepts no byte.
  always_comb begin
    state_n   = state_q;
    busy      = 1'b0;
    push      = 1'b0;
    push_sel  = dest_q;
    load_dest = 1'b0;
    drop_inc  = 1'b0;
    par_chk   = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_status) begin
          if (match_hit) begin
            push_sel = match_idx;
            if (full[match_idx]) begin
              busy = 1'b1;
            end else begin
              push      = 1'b1;
              load_dest = 1'b1;
              state_n   = LOAD;
            end
          end else begin
            drop_inc = 1'b1;
            state_n  = DROP;
          end
        end
      end
      LOAD: begin
        if (full[dest_q]) begin
          busy = 1'b1;
        end else begin
          push = 1'b1;
          if (!data_status) begin
            par_chk = 1'b1;
            state_n = IDLE;
          end
        end
      end
      DROP: begin
        if (!data_status) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state, latched destination, drop counter and parity pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      dest_q     <= '0;
      drop_count <= 8'd0;
      parity_err <= 1'b0;
    end else begin
      state_q    <= state_n;
      parity_err <= par_chk && (data != xor_acc);
      if (load_dest) dest_q <= match_idx;
      if (drop_inc) drop_count <= sat_inc8(drop_count);
    end
  end

  // Running parity over header and payload; always reloaded by the header.
  always_ff @(posedge clk) begin
    if (load_dest) begin
      xor_acc <= data;
    end else if (state_q == LOAD && push && data_status) begin
      xor_acc <= xor_acc ^ data;
    end
  end

  // Address registers and registered config readback.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++) addr_reg[i] <= DATA_W'(i);
      mem_rd_data <= '0;
    end else if (mem_en && add_ok) begin
      if (mem_rd_wr) addr_reg[mem_add] <= mem_data;
      else           mem_rd_data      <= addr_reg[mem_add];
    end else if (mem_en && !mem_rd_wr) begin
      mem_rd_data <= '0;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    cnt;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [DATA_W-1:0] port_q;
    logic              wr_en, rd_en;

    assign full[g]  = (cnt == CNT_FULL);
    assign ready[g] = (cnt != '0);
    assign wr_en    = push && (push_sel == SEL_W'(g)) && !full[g];
    assign rd_en    = read[g] && ready[g];
    assign port[g*DATA_W +: DATA_W] = port_q;

    // FIFO pointers, occupancy and registered head-of-queue output.
    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        port_q <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
        if (rd_en) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
          port_q <= mem[rd_ptr];
        end
        case ({wr_en, rd_en})
          2'b10:   cnt <= cnt + (PTR_W+1)'(1);
          2'b01:   cnt <= cnt - (PTR_W+1)'(1);
          default: cnt <= cnt;
        endcase
      end
    end

    // FIFO storage; contents are meaningless until the pointers cover them.
    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= data;
    end
  end

endmodule

// File: tb/tb_router_nport.sv
// Self-checking bench for router_nport with a queue-based reference model.
module tb_router_nport;
  localparam int NP = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          data_status = 1'b0;
  logic [7:0]    data = 8'h00;
  logic          busy;
  logic          mem_en = 1'b0;
  logic          mem_rd_wr = 1'b0;
  logic [1:0]    mem_add = 2'd0;
  logic [7:0]    mem_data = 8'h00;
  logic [7:0]    mem_rd_data;
  logic [NP-1:0] read = '0;
  logic [NP*DW-1:0] port;
  logic [NP-1:0] ready;
  logic          parity_err;
  logic [7:0]    drop_count;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] m_addr [NP];
  int         m_drop;
  logic [7:0] expq [NP][$];
  logic [7:0] pkt [$];
  logic [7:0] got [$];

  router_nport #(.NUM_PORTS(NP), .DATA_W(DW), .FIFO_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .data_status(data_status), .data(data),
    .busy(busy), .mem_en(mem_en), .mem_rd_wr(mem_rd_wr), .mem_add(mem_add),
    .mem_data(mem_data), .mem_rd_data(mem_rd_data), .read(read), .port(port),
    .ready(ready), .parity_err(parity_err), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lookup(input logic [7:0] h);
    for (int i = 0; i < NP; i++) if (m_addr[i] == h) return i;
    return -1;
  endfunction

  function automatic logic [NP-1:0] model_ready();
    logic [NP-1:0] r;
    for (int i = 0; i < NP; i++) r[i] = (expq[i].size() != 0);
    return r;
  endfunction

  function automatic int count_diffs(input int p);
    int d;
    d = (got.size() != expq[p].size()) ? 1 : 0;
    for (int i = 0; i < got.size() && i < expq[p].size(); i++)
      if (got[i] !== expq[p][i]) d++;
    return d;
  endfunction

  task automatic do_reset();
    reset = 1'b1; data_status = 1'b0; data = 8'h00; mem_en = 1'b0; read = '0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NP; i++) begin
      m_addr[i] = 8'(i);
      expq[i].delete();
    end
    m_drop = 0;
  endtask

  task automatic cfg_write(input int idx, input logic [7:0] val);
    mem_en = 1'b1; mem_rd_wr = 1'b1; mem_add = 2'(idx); mem_data = val;
    tick();
    mem_en = 1'b0;
    m_addr[idx] = val;
  endtask

  task automatic cfg_read(input int idx, output logic [7:0] val);
    mem_en = 1'b1; mem_rd_wr = 1'b0; mem_add = 2'(idx);
    tick();
    mem_en = 1'b0;
    val = mem_rd_data;
  endtask

  // Present one byte, wait out busy (bounded), then let it be accepted.
  task automatic send_byte(input logic st, input logic [7:0] d, output logic perr);
    int n;
    n = 0;
    data_status = st; data = d;
    #1;
    while (busy && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) begin
      tests_run++; tests_failed++;
      $display("FAIL send_timeout: busy stuck high, byte %02h not accepted", d);
    end
    tick();
    perr = parity_err;
  endtask

  // Send pkt (last byte is parity); counts parity pulses incl. one trailing cycle.
  task automatic send_pkt(output int perr_cnt, output logic perr_last);
    logic pe;
    perr_cnt = 0; perr_last = 1'b0;
    for (int i = 0; i < pkt.size(); i++) begin
      send_byte(i != pkt.size() - 1, pkt[i], pe);
      if (pe) perr_cnt++;
      perr_last = pe;
    end
    data_status = 1'b0; data = 8'h00;
    tick();
    if (parity_err) perr_cnt++;
  endtask

  task automatic model_pkt(output int exp_perr);
    int k;
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < pkt.size() - 1; i++) x ^= pkt[i];
    k = lookup(pkt[0]);
    exp_perr = 0;
    if (k >= 0) begin
      for (int i = 0; i < pkt.size(); i++) expq[k].push_back(pkt[i]);
      exp_perr = (x != pkt[pkt.size()-1]) ? 1 : 0;
    end else begin
      m_drop = (m_drop < 255) ? m_drop + 1 : 255;
    end
  endtask

  task automatic drain_port(input int p);
    int n;
    n = 0;
    got.delete();
    while (ready[p] && n < 64) begin
      read = '0; read[p] = 1'b1;
      tick();
      read = '0;
      got.push_back(port[p*8 +: 8]);
      n++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    do_reset();
    tests_run++; if (ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_ready: got %b want 0000", ready); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (drop_count !== 8'd0 || parity_err !== 1'b0) begin tests_failed++; $display("FAIL reset_cnt: drop %0d perr %b want 0 0", drop_count, parity_err); end
    tests_run++; if (port !== '0 || mem_rd_data !== 8'h00) begin tests_failed++; $display("FAIL reset_outs: port %h rd %h want 0", port, mem_rd_data); end
    cfg_read(2, v);
    tests_run++; if (v !== 8'd2) begin tests_failed++; $display("FAIL reset_addr2: got %h want 02", v); end
  endtask

  task automatic test_route();
    logic [7:0] v;
    int pc, ep; logic pl;
    cfg_write(1, 8'h55);
    cfg_read(1, v);
    tests_run++; if (v !== 8'h55) begin tests_failed++; $display("FAIL cfg_readback: got %h want 55", v); end
    pkt = '{8'h55, 8'h11, 8'h22, 8'h66};
    model_pkt(ep);
    send_pkt(pc, pl);
    tests_run++; if (ready !== model_ready()) begin tests_failed++; $display("FAIL route_ready: got %b want %b", ready, model_ready()); end
    tests_run++; if (pc !== ep) begin tests_failed++; $display("FAIL route_perr: got %0d pulses want %0d", pc, ep); end
    drain_port(1);
    tests_run++; if (count_diffs(1) != 0) begin tests_failed++; $display("FAIL route_data: got %p want %p", got, expq[1]); end
    expq[1].delete();
  endtask

  task automatic test_parity();
    int pc, ep; logic pl;
    pkt = '{8'h55, 8'h11, 8'h22, 8'h00};
    model_pkt(ep);
    send_pkt(pc, pl);
    tests_run++; if (pl !== 1'b1) begin tests_failed++; $display("FAIL parity_timing: got %b want 1 after parity byte", pl); end
    tests_run++; if (pc !== ep) begin tests_failed++; $display("FAIL parity_pulses: got %0d want %0d", pc, ep); end
    drain_port(1);
    tests_run++; if (count_diffs(1) != 0) begin tests_failed++; $display("FAIL parity_data: got %p want %p", got, expq[1]); end
    expq[1].delete();
  endtask

  task automatic test_drop();
    int pc, ep; logic pl;
    pkt = '{8'hEE, 8'h01, 8'h02};
    model_pkt(ep);
    send_pkt(pc, pl);
    tests_run++; if (ready !== 4'b0000) begin tests_failed++; $display("FAIL drop_ready: got %b want 0000", ready); end
    tests_run++; if (drop_count !== 8'(m_drop)) begin tests_failed++; $display("FAIL drop_one: got %0d want %0d", drop_count, m_drop); end
    for (int i = 0; i < 256; i++) begin
      pkt = '{8'hEE, 8'h00};
      model_pkt(ep);
      send_pkt(pc, pl);
    end
    tests_run++; if (drop_count !== 8'(m_drop)) begin tests_failed++; $display("FAIL drop_sat: got %0d want %0d", drop_count, m_drop); end
  endtask

  task automatic test_backpressure();
    logic [7:0] b [20];
    int idx, cyc, busy_early, perrs;
    logic popping, check_next, b_now, r_now, rd;
    b[0] = 8'h00; b[19] = 8'h00;
    for (int i = 1; i < 19; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 19; i++) b[19] ^= b[i];
    idx = 0; cyc = 0; busy_early = 0; perrs = 0;
    popping = 1'b0; check_next = 1'b0;
    got.delete();
    while ((idx < 20 || got.size() < 20) && cyc < 300) begin
      if (idx < 20) begin data_status = (idx < 19); data = b[idx]; end
      else begin data_status = 1'b0; data = 8'h00; end
      #1;
      b_now = busy; r_now = ready[0];
      if (check_next) begin
        tests_run++; if (b_now !== 1'b0) begin tests_failed++; $display("FAIL bp_release: busy %b want 0 after one read", b_now); end
        check_next = 1'b0;
      end
      if (!popping && idx == 16) begin
        tests_run++; if (b_now !== 1'b1) begin tests_failed++; $display("FAIL bp_full: busy %b want 1 after 16 pushes", b_now); end
        read[0] = 1'b1; popping = 1'b1; check_next = 1'b1;
      end else if (!popping) begin
        if (b_now) busy_early++;
        read = '0;
      end else begin
        read[0] = r_now;
      end
      rd = read[0];
      @(posedge clk); #1;
      if (idx < 20 && !b_now) idx++;
      if (rd) got.push_back(port[7:0]);
      read = '0;
      if (parity_err) perrs++;
      cyc++;
    end
    data_status = 1'b0; data = 8'h00;
    tests_run++; if (idx != 20 || got.size() != 20) begin tests_failed++; $display("FAIL bp_progress: sent %0d recv %0d want 20 20", idx, got.size()); end
    tests_run++; if (busy_early != 0) begin tests_failed++; $display("FAIL bp_early: busy seen %0d times before full, want 0", busy_early); end
    for (int i = 0; i < 20; i++) expq[0].push_back(b[i]);
    tests_run++; if (count_diffs(0) != 0) begin tests_failed++; $display("FAIL bp_order: got %p want %p", got, expq[0]); end
    tests_run++; if (perrs != 0 || ready !== 4'b0000) begin tests_failed++; $display("FAIL bp_end: perr %0d ready %b want 0 0000", perrs, ready); end
    expq[0].delete();
  endtask

  task automatic test_reset_mid();
    logic pe;
    logic [7:0] v;
    int pc, ep; logic pl;
    send_byte(1'b1, 8'h55, pe);
    send_byte(1'b1, 8'h21, pe);
    send_byte(1'b1, 8'h42, pe);
    reset = 1'b1; data_status = 1'b1; data = 8'h33;
    tick();
    reset = 1'b0; data_status = 1'b0; data = 8'h00;
    for (int i = 0; i < NP; i++) begin m_addr[i] = 8'(i); expq[i].delete(); end
    m_drop = 0;
    tests_run++; if (ready !== 4'b0000 || busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_clear: ready %b busy %b want 0000 0", ready, busy); end
    tests_run++; if (drop_count !== 8'd0) begin tests_failed++; $display("FAIL midrst_drop: got %0d want 0", drop_count); end
    cfg_read(1, v);
    tests_run++; if (v !== 8'h01) begin tests_failed++; $display("FAIL midrst_addr: got %h want 01", v); end
    pkt = '{8'h02, 8'hA5, 8'hA7};
    model_pkt(ep);
    send_pkt(pc, pl);
    tests_run++; if (ready !== 4'b0100 || pc != ep) begin tests_failed++; $display("FAIL midrst_route: ready %b perr %0d want 0100 %0d", ready, pc, ep); end
    drain_port(2);
    tests_run++; if (count_diffs(2) != 0) begin tests_failed++; $display("FAIL midrst_data: got %p want %p", got, expq[2]); end
    expq[2].delete();
  endtask

  task automatic test_random();
    int pc, ep, len;
    logic pl;
    logic [7:0] x;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) cfg_write($urandom_range(0, NP-1), 8'($urandom_range(0, 7)));
      pkt.delete();
      pkt.push_back(8'($urandom_range(0, 9)));
      len = $urandom_range(0, 4);
      for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
      x = 8'h00;
      foreach (pkt[i]) x ^= pkt[i];
      if ($urandom_range(0, 3) == 0) x ^= 8'(1 << $urandom_range(0, 7));
      pkt.push_back(x);
      model_pkt(ep);
      send_pkt(pc, pl);
      tests_run++; if (pc != ep) begin tests_failed++; $display("FAIL rnd_perr[%0d]: got %0d want %0d", n, pc, ep); end
      tests_run++; if (drop_count !== 8'(m_drop)) begin tests_failed++; $display("FAIL rnd_drop[%0d]: got %0d want %0d", n, drop_count, m_drop); end
      tests_run++; if (ready !== model_ready()) begin tests_failed++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, ready, model_ready()); end
      for (int p = 0; p < NP; p++) begin
        if (expq[p].size() > 9 || $urandom_range(0, 1) == 0 || n == 39) begin
          drain_port(p);
          tests_run++; if (count_diffs(p) != 0) begin tests_failed++; $display("FAIL rnd_data[%0d] port %0d: got %p want %p", n, p, got, expq[p]); end
          expq[p].delete();
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_route();
    test_parity();
    test_drop();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
